// File: rtl/count_mon_pkg.sv
// Shared types and constants for the counter stream monitor.
package count_mon_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StTrack,
    StPass,
    StFail
  } mon_state_t;

  localparam int unsigned ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = 8'd255;

endpackage

// File: rtl/mon_watchdog.sv
// Inactivity timer: counts enabled cycles since the last clear and pulses
// expired on the cycle whose edge would bring the count to TIMEOUT.
module mon_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset_l,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count and expiry pulse; clear wins over enable.
  always_comb begin
    cnt_d   = cnt_q;
    expired = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == CntW'(TIMEOUT - 1)) begin
        expired = 1'b1;
      end
      if (cnt_q != CntW'(TIMEOUT)) begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/count_stream_monitor.sv
// Checks a valid-qualified counter stream for +1 steps (mod 2^WIDTH) and
// produces a sticky pass/fail verdict, mismatch count and coverage flag.
module count_stream_monitor
  import count_mon_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned TARGET    = 4,
  parameter int unsigned TIMEOUT   = 64,
  parameter int unsigned COVER_VAL = 3
) (
  input  logic             clk,
  input  logic             reset_l,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [ERR_W-1:0] err_cnt,
  output logic [WIDTH-1:0] last_seen,
  output logic             cover_hit
);

  localparam int unsigned SeqW = $clog2(TARGET + 1);

  mon_state_t       state_q, state_d;
  logic [SeqW-1:0]  seq_q, seq_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic             cover_q, cover_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic             done_q, done_d;

  logic active;
  logic wd_expired;

  assign active = (state_q == StArm) || (state_q == StTrack);

  mon_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset_l(reset_l),
    .enable (active && !start),
    .clear  (start || in_valid || !active),
    .expired(wd_expired)
  );

  // Next-state: start overrides everything; samples only count in ARM/TRACK.
  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    exp_d   = exp_q;
    err_d   = err_q;
    last_d  = last_q;
    cover_d = cover_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    done_d  = done_q;

    if (start) begin
      state_d = StArm;
      seq_d   = '0;
      err_d   = '0;
      cover_d = 1'b0;
      pass_d  = 1'b0;
      fail_d  = 1'b0;
      done_d  = 1'b0;
    end else if (active && in_valid) begin
      last_d  = in_data;
      exp_d   = in_data + WIDTH'(1);
      state_d = StTrack;
      if (in_data == WIDTH'(COVER_VAL)) begin
        cover_d = 1'b1;
      end
      if (state_q == StTrack && in_data == exp_q) begin
        seq_d = seq_q + SeqW'(1);
      end else begin
        seq_d = SeqW'(1);
        if (state_q == StTrack && err_q != ERR_MAX) begin
          err_d = err_q + ERR_W'(1);
        end
      end
      if (seq_d == SeqW'(TARGET)) begin
        done_d = 1'b1;
        if (err_d == '0) begin
          state_d = StPass;
          pass_d  = 1'b1;
        end else begin
          state_d = StFail;
          fail_d  = 1'b1;
        end
      end
    end else if (wd_expired) begin
      state_d = StFail;
      fail_d  = 1'b1;
      done_d  = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q <= StIdle;
      seq_q   <= '0;
      exp_q   <= '0;
      err_q   <= '0;
      last_q  <= '0;
      cover_q <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      exp_q   <= exp_d;
      err_q   <= err_d;
      last_q  <= last_d;
      cover_q <= cover_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      done_q  <= done_d;
    end
  end

  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign err_cnt   = err_q;
  assign last_seen = last_q;
  assign cover_hit = cover_q;

endmodule

// File: doc/count_stream_monitor.md
Name: count_stream_monitor

Overview:
- Receiving end of a free-running counter stream: samples a valid-qualified count value each cycle and checks it increments by exactly one (mod 2^WIDTH).
- Declares pass/fail with a sticky verdict, counts mismatches, and runs an inactivity watchdog.
- Raises a sticky coverage flag when a chosen value is observed.
- Sits in the Verilator example bench beside the counter block and replaces ad-hoc $finish checks with a synthesizable verdict.

Parameters:
- WIDTH, 32, width of counter samples.
- TARGET, 4, consecutive in-sequence samples (including the base sample) needed to end the run.
- TIMEOUT, 64, cycles without in_valid (in ARM/TRACK) before forced fail.
- COVER_VAL, 3, sample value that sets cover_hit.

Ports:
- clk  input  1  single clock, rising edge.
- reset_l  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse: arm or re-arm the monitor.
- in_valid  input  1  sample qualifier.
- in_data  input  WIDTH  counter sample.
- done  output  1  run finished (PASS or FAIL), sticky.
- pass  output  1  verdict good, sticky.
- fail  output  1  verdict bad, sticky.
- err_cnt  output  8  mismatch count, saturating.
- last_seen  output  WIDTH  last accepted sample.
- cover_hit  output  1  sticky, COVER_VAL seen since arm.

Behaviour:
- Reset (reset_l low, takes effect asynchronously):
  - State goes to IDLE; all outputs and internal counters go to 0.
  - Reset mid-run discards the run; no verdict is produced until the next start.
- States: IDLE, ARM, TRACK, PASS, FAIL. All outputs are registered.
- IDLE: in_valid ignored. start -> ARM.
- ARM: first in_valid sample is the base.
  - last_seen = in_data; expected = in_data+1; seq_cnt = 1.
  - Go to TRACK.
- TRACK, on each in_valid:
  - If in_data == expected: seq_cnt++, expected++.
  - Else: err_cnt++ (saturating at 255), expected = in_data+1 (resync), seq_cnt = 1.
  - last_seen = in_data in both cases.
- Verdict: when seq_cnt reaches TARGET, next state is PASS if err_cnt == 0, otherwise FAIL.
  - done and pass/fail assert on the cycle after the completing sample's edge.
- Arithmetic: expected wraps modulo 2^WIDTH. All-ones followed by 0 is in-sequence, not an error.
- Watchdog (ARM and TRACK only):
  - Idle timer clears on in_valid and increments otherwise.
  - When the timer reaches TIMEOUT -> FAIL, without changing err_cnt.
  - The timer is held at 0 in IDLE, PASS and FAIL.
- PASS/FAIL are terminal:
  - done, pass/fail and err_cnt hold; in_valid is ignored.
  - start -> ARM.
- start priority:
  - start is honoured in any state.
  - On start, go to ARM and clear err_cnt, cover_hit, done, pass, fail, seq_cnt and the idle timer. last_seen holds.
  - An in_valid in the same cycle as start is dropped.
- cover_hit: set when an accepted sample (ARM or TRACK) equals COVER_VAL; cleared only by start or reset.
- Invariants:
  - pass and fail are never both 1.
  - done == pass | fail.

Decomposition:
- Package count_mon_pkg holds:
  - mon_state_t enum (IDLE, ARM, TRACK, PASS, FAIL).
  - ERR_W = 8 and ERR_MAX = 255.
- One sub-module, mon_watchdog: parameterised idle counter.
  - Inputs: enable, clear.
  - Output: expired pulse.
  - Same clk/reset_l.
- Sequence comparison and the FSM stay in the top module.

Test Plan:
1. Reset; start; in_valid with 0,1,2,3 on consecutive cycles -> pass=1 and done=1 the cycle after sample 3; err_cnt=0; cover_hit=1; last_seen=3.
2. start; samples 0,1,5,6,7,8 -> err_cnt=1; fail=1 after sample 8; pass stays 0; last_seen=8.
3. start; samples FFFFFFFE,FFFFFFFF,0,1 -> pass=1, err_cnt=0 (wrap is not an error); cover_hit=0.
4. start; sample 0; then in_valid low -> fail=1 exactly 64 cycles after the sample 0 edge; err_cnt=0.
5. Mid-TRACK (after samples 0,1), drop reset_l between clock edges -> all outputs 0 immediately. Release reset, feed 2,3,4,5 without start -> done stays 0.
6. In TRACK, assert start together with in_valid and data 9, then feed 10,11,12,13 -> the 9 is dropped and 10 becomes the base; pass=1 after 13; err_cnt=0.
